// File: rtl/reg_file.sv
// reg_file: 2R1W register file with load-pending scoreboard, optional write-to-read bypass and stall generation.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] AD1,
  input  logic [ADDRESS_WIDTH-1:0] AD2,
  input  logic [ADDRESS_WIDTH-1:0] AD3,
  input  logic                     WE3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  input  logic                     LdIssue,
  input  logic [ADDRESS_WIDTH-1:0] LdRd,
  output logic [DATA_WIDTH-1:0]    RD1,
  output logic [DATA_WIDTH-1:0]    RD2,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic                     Stall
);
  localparam int N = 2 ** ADDRESS_WIDTH;
  logic [DATA_WIDTH-1:0] regs [N];
  logic [N-1:0] busy;
  logic wr, ld, fwd1, fwd2;
  assign wr = WE3 && AD3 != '0;
  assign ld = LdIssue && LdRd != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr) regs[AD3] <= WD3;
      if (wr) busy[AD3] <= 1'b0;
      // a load re-targeting the register being written back keeps it pending
      if (ld) busy[LdRd] <= 1'b1;
    end
  end
  always_comb begin
    fwd1 = BYPASS != 0 && wr && AD3 == AD1;
    fwd2 = BYPASS != 0 && wr && AD3 == AD2;
    RD1 = AD1 == '0 ? '0 : fwd1 ? WD3 : regs[AD1];
    RD2 = AD2 == '0 ? '0 : fwd2 ? WD3 : regs[AD2];
    a0 = regs[10];
    Stall = (busy[AD1] && !fwd1) || (busy[AD2] && !fwd2);
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: checks bypassing and non-bypassing reg_file instances against an array-based model plus directed literals.
module tb_reg_file;
  logic clk = 0, rst = 0, WE3 = 0, LdIssue = 0;
  logic [4:0] AD1 = 0, AD2 = 0, AD3 = 0, LdRd = 0;
  logic [31:0] WD3 = 0;
  logic [31:0] rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n;
  logic stall_b, stall_n;
  int n_checks = 0, n_fail = 0;
  logic [31:0] mreg [32];
  bit mbusy [32];
  bit started = 0;

  always #5 clk = ~clk;

  reg_file #(.BYPASS(1)) u_b (.clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .WD3(WD3),
    .LdIssue(LdIssue), .LdRd(LdRd), .RD1(rd1_b), .RD2(rd2_b), .a0(a0_b), .Stall(stall_b));
  reg_file #(.BYPASS(0)) u_n (.clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .WD3(WD3),
    .LdIssue(LdIssue), .LdRd(LdRd), .RD1(rd1_n), .RD2(rd2_n), .a0(a0_n), .Stall(stall_n));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && WE3 && AD3 != 0 && AD3 == a) return WD3;
    return mreg[a];
  endfunction

  function automatic bit exp_stall(input bit byp);
    bit p1 = mbusy[AD1] && !(byp && WE3 && AD3 == AD1);
    bit p2 = mbusy[AD2] && !(byp && WE3 && AD3 == AD2);
    return p1 || p2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i] = 0;
        mbusy[i] = 0;
      end
      started = 1;
    end else begin
      if (WE3 && AD3 != 0) begin
        mreg[AD3] = WD3;
        mbusy[AD3] = 0;
      end
      if (LdIssue && LdRd != 0) mbusy[LdRd] = 1;
    end
  end

  always @(negedge clk) if (started) begin
    chk("model_rd1_byp", rd1_b, exp_rd(AD1, 1));
    chk("model_rd2_byp", rd2_b, exp_rd(AD2, 1));
    chk("model_a0_byp", a0_b, mreg[10]);
    chk("model_stall_byp", {31'b0, stall_b}, {31'b0, exp_stall(1)});
    chk("model_rd1_nobyp", rd1_n, exp_rd(AD1, 0));
    chk("model_rd2_nobyp", rd2_n, exp_rd(AD2, 0));
    chk("model_a0_nobyp", a0_n, mreg[10]);
    chk("model_stall_nobyp", {31'b0, stall_n}, {31'b0, exp_stall(0)});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    tick();
    rst = 0; AD1 = 5; AD2 = 10;
    #1;
    chk("rst_rd1", rd1_b, 0); chk("rst_rd2", rd2_n, 0);
    chk("rst_a0", a0_b, 0); chk("rst_stall", {31'b0, stall_b | stall_n}, 0);
    WE3 = 1; AD3 = 10; WD3 = 32'hAB; AD1 = 10; AD2 = 10;
    #1;
    chk("byp_rd1", rd1_b, 32'hAB); chk("byp_rd2_same", rd2_b, 32'hAB);
    chk("nobyp_rd1", rd1_n, 0); chk("a0_not_bypassed", a0_b, 0);
    tick();
    WE3 = 0;
    #1;
    chk("a0_next", a0_b, 32'hAB); chk("nobyp_rd1_next", rd1_n, 32'hAB); chk("a0_next_nobyp", a0_n, 32'hAB);
    WE3 = 1; AD3 = 0; WD3 = 32'hFFFF_FFFF; AD1 = 0;
    #1;
    chk("x0_write_same", rd1_b, 0);
    tick();
    WE3 = 0;
    #1;
    chk("x0_write_next", rd1_b, 0);
    LdIssue = 1; LdRd = 0;
    tick();
    LdIssue = 0;
    #1;
    chk("x0_load_stall", {31'b0, stall_b | stall_n}, 0);
    LdIssue = 1; LdRd = 7; AD2 = 0;
    #1;
    chk("load_same_cycle", {31'b0, stall_b}, 0);
    tick();
    LdIssue = 0; AD2 = 7;
    #1;
    chk("pend_n1", {31'b0, stall_b}, 1);
    tick();
    chk("pend_n2", {31'b0, stall_n}, 1);
    WE3 = 1; AD3 = 7; WD3 = 32'h1234;
    #1;
    chk("wb_stall_byp", {31'b0, stall_b}, 0); chk("wb_rd2_byp", rd2_b, 32'h1234);
    chk("wb_stall_nobyp", {31'b0, stall_n}, 1);
    tick();
    WE3 = 0;
    #1;
    chk("after_wb_nobyp", {31'b0, stall_n}, 0); chk("after_wb_rd2", rd2_n, 32'h1234);
    LdIssue = 1; LdRd = 7; AD2 = 0;
    tick();
    WE3 = 1; AD3 = 7; WD3 = 32'h5555; AD1 = 3;
    tick();
    WE3 = 0; LdIssue = 0; AD1 = 7;
    #1;
    chk("set_wins_stall", {31'b0, stall_b}, 1); chk("set_wins_rd1", rd1_b, 32'h5555);
    WE3 = 1; AD3 = 7;
    tick();
    WE3 = 0;
    for (int i = 1; i < 8; i++) begin
      WE3 = 1; AD3 = 5'(i * 3); WD3 = 32'h1000 + i; AD1 = 5'(i * 3); AD2 = 5'(i * 3 - 3);
      tick();
    end
    WE3 = 0; AD1 = 12; AD2 = 21;
    #1;
    chk("table_rd1", rd1_n, 32'h1004); chk("table_rd2", rd2_b, 32'h1007);
    LdIssue = 1; LdRd = 9;
    tick();
    LdIssue = 0; AD1 = 9; AD2 = 0;
    #1;
    chk("x9_pending", {31'b0, stall_b}, 1);
    rst = 1; WE3 = 1; AD3 = 12; WD3 = 32'h77; LdIssue = 1; LdRd = 12;
    #1;
    chk("rst_cycle_prestate", {31'b0, stall_b}, 1);
    tick();
    rst = 0; WE3 = 0; LdIssue = 0; AD2 = 12;
    #1;
    chk("post_rst_stall", {31'b0, stall_b | stall_n}, 0); chk("post_rst_rd1", rd1_b, 0);
    chk("post_rst_rd2", rd2_b, 0); chk("post_rst_a0", a0_n, 0);
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and data port.
REQ-002 Parameter ADDRESS_WIDTH, default 5, register index width; register count is 2^ADDRESS_WIDTH.
REQ-003 Parameter BYPASS, default 1, enables write-to-read forwarding when 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 AD1  input  ADDRESS_WIDTH  read port 1 index (rs1).
REQ-007 AD2  input  ADDRESS_WIDTH  read port 2 index (rs2).
REQ-008 AD3  input  ADDRESS_WIDTH  write port index (rd).
REQ-009 WE3  input  1  write enable for port 3.
REQ-010 WD3  input  DATA_WIDTH  write data.
REQ-011 LdIssue  input  1  load issued this cycle; its destination becomes pending.
REQ-012 LdRd  input  ADDRESS_WIDTH  destination index of the issued load.
REQ-013 RD1  output  DATA_WIDTH  read data 1; feeds ALUop1.
REQ-014 RD2  output  DATA_WIDTH  read data 2; feeds the ALUop2 mux.
REQ-015 a0  output  DATA_WIDTH  stored contents of register 10 (observation port).
REQ-016 Stall  output  1  a source operand is pending a load; the upstream stage shall hold.

Function
REQ-017 Storage: 2^ADDRESS_WIDTH registers of DATA_WIDTH bits plus one busy bit per register.
REQ-018 Write: at the rising edge, when WE3=1 and AD3!=0, reg[AD3] <= WD3; AD3=0 writes are discarded.
REQ-019 Read: RD1/RD2 combinational from AD1/AD2 with zero read latency; index 0 reads 0 regardless of any write.
REQ-020 Bypass (BYPASS=1): when WE3=1, AD3!=0 and AD3==ADx, RDx = WD3 in the same cycle; with BYPASS=0, RDx shows the stored value and the new value is visible the cycle after.
REQ-021 Both read ports addressing the same register return identical values, including the bypass case.
REQ-022 a0 = reg[10] stored value, never bypassed; it updates the cycle after a write to index 10.
REQ-023 Busy set: at the rising edge, when LdIssue=1 and LdRd!=0, busy[LdRd] <= 1.
REQ-024 Busy clear: at the rising edge, when WE3=1 and AD3!=0, busy[AD3] <= 0.
REQ-025 Simultaneous set and clear of the same index: set wins, so busy stays 1 for the new load.
REQ-026 busy[0] is constant 0; LdIssue with LdRd=0 has no effect.
REQ-027 Stall = src1_pend OR src2_pend, purely combinational from current busy and inputs; srcN_pend = busy[ADN] AND NOT (BYPASS=1 AND WE3=1 AND AD3==ADN).
REQ-028 With BYPASS=0, Stall stays asserted during the writeback cycle and deasserts the cycle after.
REQ-029 Stall never asserts for index 0, and does not depend on LdIssue in the same cycle.
REQ-030 Reads, bypass and Stall are unaffected by LdIssue in the same cycle; a load issued at cycle N first affects Stall at N+1.

Reset
REQ-031 While rst=1 at a rising edge, all registers <= 0 and all busy bits <= 0; after that edge RD1=RD2=a0=0 and Stall=0.
REQ-032 rst dominates: WE3 and LdIssue asserted in a reset cycle have no effect.
REQ-033 Reset asserted while loads are pending clears every busy bit; Stall=0 in the cycle after the reset edge.
REQ-034 Combinational outputs during the rst=1 cycle reflect pre-reset state; no output is forced by rst before the edge.

Verification
REQ-035 Reset, then AD1=5, AD2=10 -> RD1=0, RD2=0, a0=0, Stall=0.
REQ-036 WE3=1, AD3=10, WD3=0x0000_00AB, AD1=10, BYPASS=1 -> RD1=0xAB the same cycle; a0=0xAB the next cycle; repeat with BYPASS=0 -> RD1=0 this cycle, 0xAB the next.
REQ-037 WE3=1, AD3=0, WD3=0xFFFF_FFFF, then AD1=0 -> RD1=0; LdIssue=1, LdRd=0, then AD1=0 -> Stall=0.
REQ-038 LdIssue=1, LdRd=7 at cycle N; AD2=7 at N+1, N+2 -> Stall=1; writeback WE3=1, AD3=7, WD3=0x1234 at N+3 -> Stall=0 at N+3 (BYPASS=1), RD2=0x1234.
REQ-039 Same cycle: WE3=1, AD3=7 and LdIssue=1, LdRd=7 with busy[7]=1 -> busy[7] remains 1; AD1=7 next cycle -> Stall=1, RD1 = written value.
REQ-040 Load pending on x9, rst=1 for one cycle -> Stall=0 with AD1=9 after the reset edge; RD1=0.
